// File: rtl/usr_serializer_ctrl.sv
// Sequencer that drives a universal shift register to serialize one parallel word per handshake.
// Optional MSB-first direction per word: define USR_CTRL_MSB_FIRST_EN.
module usr_serializer_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
`ifdef USR_CTRL_MSB_FIRST_EN
    input  logic             s_msb_first,
`endif
    output logic [1:0]       usr_mode,
    output logic [WIDTH-1:0] usr_in,
    input  logic [WIDTH-1:0] usr_out,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] usr_in_q, usr_in_d;
    logic             dir_q, dir_d;
    logic             msb_sel;
    logic [CW-1:0]    bit_idx;

`ifdef USR_CTRL_MSB_FIRST_EN
    assign msb_sel = s_msb_first;
`else
    assign msb_sel = 1'b0;
`endif

    // Tap position of the outgoing bit: top of the register for MSB-first, bottom otherwise.
    assign bit_idx = dir_q ? CW'(WIDTH - 1) : '0;
    assign usr_in  = usr_in_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            usr_in_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            usr_in_q <= usr_in_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        usr_in_d  = usr_in_q;
        dir_d     = dir_q;
        s_ready   = 1'b0;
        usr_mode  = 2'b00;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    usr_in_d = s_data;
                    dir_d    = msb_sel;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                usr_mode = 2'b11;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = usr_out[bit_idx];
                if (ser_ready) begin
                    usr_mode = dir_q ? 2'b10 : 2'b01;
                    // Counter stops at the last bit rather than wrapping.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_serializer_ctrl.sv
// Self-checking bench: word-level reference model plus directed and random stimulus.
// Build with USR_CTRL_MSB_FIRST_EN to exercise MSB-first words.
module tb_usr_serializer_ctrl;
    localparam int W = 4;

`ifdef USR_CTRL_MSB_FIRST_EN
    localparam bit MSB_EN = 1'b1;
`else
    localparam bit MSB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_msb_first;
    logic [1:0]   usr_mode;
    logic [W-1:0] usr_in;
    logic [W-1:0] usr_out;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_ready;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    usr_serializer_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
`ifdef USR_CTRL_MSB_FIRST_EN
        .s_msb_first (s_msb_first),
`endif
        .usr_mode    (usr_mode),
        .usr_in      (usr_in),
        .usr_out     (usr_out),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .ser_ready   (ser_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Universal shift register datapath (not cleared by reset).
    logic [W-1:0] sr_q = '0;
    always @(posedge clk) begin
        case (usr_mode)
            2'b01:   sr_q <= {1'b0, sr_q[W-1:1]};
            2'b10:   sr_q <= {sr_q[W-2:0], 1'b0};
            2'b11:   sr_q <= usr_in;
            default: sr_q <= sr_q;
        endcase
    end
    assign usr_out = sr_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is a list of W bits; k counts cycles since acceptance, b counts bits sent.
    bit           m_active = 1'b0;
    bit           m_msb    = 1'b0;
    int           m_k      = 0;
    int           m_b      = 0;
    logic [W-1:0] m_word   = '0;
    logic [W-1:0] m_usr_in = '0;

    always @(negedge clk) begin
        bit         e_valid, e_done, e_bit;
        logic [1:0] e_mode;
        if (!rst) begin
            m_active = 1'b0;
            m_usr_in = '0;
        end
        e_valid = m_active && (m_k >= 2) && (m_b < W);
        e_done  = m_active && (m_b == W);
        e_bit   = e_valid ? (m_msb ? m_word[W-1-m_b] : m_word[m_b]) : 1'b0;
        e_mode  = !m_active ? 2'b00 :
                  (m_k == 1) ? 2'b11 :
                  (e_valid && ser_ready) ? (m_msb ? 2'b10 : 2'b01) : 2'b00;
        chk("m_s_ready",   32'(s_ready),   32'(!m_active));
        chk("m_busy",      32'(busy),      32'(m_active));
        chk("m_done",      32'(done),      32'(e_done));
        chk("m_ser_valid", 32'(ser_valid), 32'(e_valid));
        chk("m_ser_out",   32'(ser_out),   32'(e_bit));
        chk("m_usr_mode",  32'(usr_mode),  32'(e_mode));
        chk("m_usr_in",    32'(usr_in),    32'(m_usr_in));
        if (rst) begin
            if (!m_active) begin
                if (s_valid) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_b      = 0;
                    m_word   = s_data;
                    m_usr_in = s_data;
                    m_msb    = MSB_EN && s_msb_first;
                    $display("word accepted data=%b msb_first=%0d at %0t", s_data, m_msb, $time);
                end
            end else if (m_b == W) begin
                m_active = 1'b0;
            end else begin
                if (e_valid && ser_ready) m_b++;
                m_k++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Sends one word from an idle cycle; seq[i] is the i-th bit expected on ser_out.
    task automatic run_word(input logic [W-1:0] data, input bit msb, input int stall,
                            input logic [W-1:0] seq, input logic [1:0] smode,
                            input bit hold, input logic [W-1:0] hold_data);
        int s;
        int bi;
        s  = (stall != 0) ? 1 : 0;
        bi = 0;
        s_valid     = 1'b1;
        s_data      = data;
        s_msb_first = msb;
        ser_ready   = 1'b1;
        for (int c = 1; c <= W + 3 + s; c++) begin
            cyc();
            s_valid   = hold;
            if (hold) s_data = hold_data;
            ser_ready = (c != stall);
            #1;
            if (hold && c <= W + 2 + s) begin
                chk("hold_s_ready", 32'(s_ready), 32'(0));
                chk("hold_usr_in",  32'(usr_in),  32'(data));
            end
            if (c == 1) begin
                chk("load_mode",   32'(usr_mode), 32'(2'b11));
                chk("load_usr_in", 32'(usr_in),   32'(data));
            end else if (c <= W + 1 + s) begin
                chk("bit_valid", 32'(ser_valid), 32'(1));
                chk("bit_value", 32'(ser_out),   32'(seq[bi]));
                if (c == stall) begin
                    chk("stall_mode", 32'(usr_mode), 32'(2'b00));
                end else begin
                    chk("shift_mode", 32'(usr_mode), 32'(smode));
                    bi++;
                end
            end else if (c == W + 2 + s) begin
                chk("done_pulse", 32'(done),      32'(1));
                chk("done_valid", 32'(ser_valid), 32'(0));
            end else begin
                chk("ready_back", 32'(s_ready), 32'(1));
                chk("done_clear", 32'(done),    32'(0));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_msb_first = 1'b0;
        ser_ready   = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_s_ready", 32'(s_ready),   32'(1));
        chk("rst_mode",    32'(usr_mode),  32'(0));
        chk("rst_valid",   32'(ser_valid), 32'(0));
        chk("rst_done",    32'(done),      32'(0));
        chk("rst_usr_in",  32'(usr_in),    32'(0));
        cyc();
        rst = 1'b1;
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 32'(1));
        chk("post_rst_busy",    32'(busy),    32'(0));

        run_word(4'b1011, 1'b0, 0, 4'b1011, 2'b01, 1'b0, 4'b0000);
        run_word(4'b1011, 1'b0, 3, 4'b1011, 2'b01, 1'b0, 4'b0000);
        run_word(4'b1011, 1'b0, 0, 4'b1011, 2'b01, 1'b1, 4'b0110);
        run_word(4'b0110, 1'b0, 0, 4'b0110, 2'b01, 1'b0, 4'b0000);
`ifdef USR_CTRL_MSB_FIRST_EN
        run_word(4'b1000, 1'b1, 0, 4'b0001, 2'b10, 1'b0, 4'b0000);
        s_msb_first = 1'b0;
`endif

        // Asynchronous reset in the middle of a word.
        s_valid   = 1'b1;
        s_data    = 4'b1011;
        ser_ready = 1'b1;
        cyc();
        s_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("arst_mode",    32'(usr_mode),  32'(0));
        chk("arst_valid",   32'(ser_valid), 32'(0));
        chk("arst_busy",    32'(busy),      32'(0));
        chk("arst_s_ready", 32'(s_ready),   32'(1));
        repeat (2) begin
            cyc();
            #1;
            chk("arst_no_done", 32'(done), 32'(0));
        end
        cyc();
        rst = 1'b1;
        run_word(4'b1011, 1'b0, 0, 4'b1011, 2'b01, 1'b0, 4'b0000);

        for (int i = 0; i < 800; i++) begin
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                repeat (2) cyc();
                rst = 1'b1;
            end
            s_valid     = ($urandom_range(0, 2) != 0);
            s_data      = W'($urandom);
            s_msb_first = 1'($urandom);
            ser_ready   = ($urandom_range(0, 3) != 0);
        end
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usr_serializer_ctrl.md
# usr_serializer_ctrl

Sequencer for the universal shift register: turns one parallel word into a bit stream by driving the register's mode and parallel-load inputs. It accepts a word over a valid/ready handshake, issues a parallel load, then issues WIDTH shift commands. Each bit is taken from the register output and presented downstream with its own valid/ready handshake. It sits between a word producer and a serial sink, with the shift register as its datapath.

## Interface
- WIDTH, 4, shift-register width in bits; must be ≥ 2
- CW, $clog2(WIDTH), bit-counter width
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- s_valid  input  1  word request
- s_ready  output  1  controller can accept a word
- s_data  input  WIDTH  word to serialize
- s_msb_first  input  1  direction for this word; present only with USR_CTRL_MSB_FIRST_EN
- usr_mode  output  2  to register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
- usr_in  output  WIDTH  to register parallel input; registered copy of s_data
- usr_out  input  WIDTH  from register output
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out is valid
- ser_ready  input  1  sink accepts the bit this cycle
- busy  output  1  high in LOAD, SHIFT and DONE
- done  output  1  one-cycle pulse after the last bit

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. State, counter, usr_in and the direction flag are registers. Outputs decode from state; usr_mode also decodes from ser_ready.
- IDLE: s_ready=1, usr_mode=00. If s_valid=1: latch s_data into usr_in, latch direction, go to LOAD.
- LOAD: usr_mode=11 for exactly one cycle, so the register loads at this edge. Clear cnt, go to SHIFT.
- SHIFT: ser_valid=1.
  - ser_out=usr_out[0] for LSB-first; ser_out=usr_out[WIDTH-1] for MSB-first.
  - If ser_ready=1: usr_mode=01 (LSB-first) or 10 (MSB-first), and cnt increments.
  - If ser_ready=0: usr_mode=00; cnt, ser_out and the register all hold.
  - Go to DONE when cnt==WIDTH-1 and ser_ready=1.
- DONE: usr_mode=00, done=1, ser_valid=0. Go to IDLE.
- Outside SHIFT: ser_out=0, ser_valid=0.
- s_ready=0 in every state except IDLE. s_valid in those states is ignored; the producer must hold it.
- cnt counts 0..WIDTH-1 and never wraps inside a word.
- Reset values of all outputs: s_ready=1, usr_mode=00, usr_in=0, ser_out=0, ser_valid=0, busy=0, done=0.
- Reset mid-operation: return to IDLE immediately and asynchronously; usr_mode becomes 00 immediately. The in-flight word is dropped with no done pulse. Register contents are not cleared by this block.

## Timing
- Word accepted at edge 0 (s_valid & s_ready).
- LOAD occupies cycle 1. The first bit is valid in cycle 2.
- With ser_ready held at 1:
  - bits appear in cycles 2..WIDTH+1
  - done is high in cycle WIDTH+2
  - s_ready returns in cycle WIDTH+3
- Throughput: one word per WIDTH+3 cycles, plus one cycle for each cycle ser_ready is low while ser_valid is high.
- A bit transfers on a rising edge when ser_valid & ser_ready are both 1.
- usr_mode responds to ser_ready in the same cycle (combinational path). The sink must not derive ser_ready combinationally from usr_mode.

## Configuration
- USR_CTRL_MSB_FIRST_EN defined:
  - s_msb_first port exists and is sampled with s_data.
  - MSB-first words use shift-left (10) and ser_out=usr_out[WIDTH-1].
- Undefined:
  - port is absent and the direction flag is constant 0.
  - always LSB-first; usr_mode never takes the value 10.

## Test plan
- Reset held low, then released: s_ready=1, usr_mode=00, ser_valid=0, done=0. Then send s_data=4'b1011, ser_ready=1 → usr_mode=11 in cycle 1, ser_out 1,1,0,1 in cycles 2–5 with usr_mode=01, done in cycle 6, s_ready=1 in cycle 7.
- Same word with ser_ready=0 in cycle 3 only → usr_mode=00 and ser_out=1 held in cycle 3, bit sequence unchanged, done in cycle 7.
- s_valid held high with new data 4'b0110 while busy → s_ready=0 and usr_in unchanged until IDLE. The word is accepted in cycle 7 and then serializes 0,1,1,0.
- With USR_CTRL_MSB_FIRST_EN, s_data=4'b1000, s_msb_first=1 → usr_mode=10 while shifting, ser_out 1,0,0,0.
- rst driven low in cycle 3 of a word → usr_mode=00, ser_valid=0, busy=0 immediately, no done pulse. After release, the next word serializes correctly from a fresh LOAD.
